// File: rtl/conv_pkg.sv
// Types and constants shared by the 2x2 convolution engine and its window feeder.
// Lane order matches the engine's byte-serial load order: lane 0 is shifted in first.
package conv_pkg;

    localparam int PIX_W = 8;
    localparam int LANES = 4;

    typedef logic [LANES-1:0][PIX_W-1:0] window_t;

    localparam int LANE_TL = 0;
    localparam int LANE_TR = 1;
    localparam int LANE_BL = 2;
    localparam int LANE_BR = 3;

endpackage

// File: rtl/line_buffer.sv
// Fixed-length pixel delay line: dout is the pixel shifted in DEPTH accepts ago.
// With DEPTH equal to the line width, that is the pixel directly above.
module line_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (shift_en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/window_gen_2x2.sv
// Turns a raster pixel stream into every overlapping 2x2 window (stride 1),
// lane-packed for the convolution engine, behind a single-stage output register.
module window_gen_2x2 #(
    parameter int IMG_WIDTH = 8,
    parameter int PIX_W     = conv_pkg::PIX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    input  logic               pix_sof,
    output logic               pix_ready,
    output logic [4*PIX_W-1:0] win_data,
    output logic               win_valid,
    output logic               win_eol,
    input  logic               win_ready
);

    import conv_pkg::*;

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    logic [COL_W-1:0]            col_q, col_d, col_eff;
    logic                        first_row_q, first_row_d, first_eff;
    logic [PIX_W-1:0]            left_cur_q, left_cur_d;
    logic [PIX_W-1:0]            left_above_q, left_above_d;
    logic [PIX_W-1:0]            above;
    logic [LANES-1:0][PIX_W-1:0] win_q, win_d;
    logic                        win_valid_q, win_valid_d;
    logic                        win_eol_q, win_eol_d;
    logic                        accept, produce, at_last;

    assign pix_ready = !win_valid_q || win_ready;
    assign accept    = pix_valid && pix_ready;

    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W)
    ) u_line_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept),
        .din      (pix_in),
        .dout     (above)
    );

    always_comb begin
        // sof re-labels the beat being accepted as (0,0); counters restart from it
        col_eff   = pix_sof ? '0 : col_q;
        first_eff = pix_sof ? 1'b1 : first_row_q;
        at_last   = (col_eff == COL_LAST);
        produce   = accept && !first_eff && (col_eff != '0);

        col_d        = col_q;
        first_row_d  = first_row_q;
        left_cur_d   = left_cur_q;
        left_above_d = left_above_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        win_eol_d    = win_eol_q;

        if (accept) begin
            col_d        = at_last ? '0 : col_eff + 1'b1;
            first_row_d  = first_eff && !at_last;
            left_cur_d   = pix_in;
            left_above_d = above;
        end

        if (produce) begin
            win_valid_d      = 1'b1;
            win_eol_d        = at_last;
            win_d[LANE_TL]   = left_above_q;
            win_d[LANE_TR]   = above;
            win_d[LANE_BL]   = left_cur_q;
            win_d[LANE_BR]   = pix_in;
        end else if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
            win_eol_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            first_row_q  <= 1'b1;
            left_cur_q   <= '0;
            left_above_q <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            win_eol_q    <= 1'b0;
        end else begin
            col_q        <= col_d;
            first_row_q  <= first_row_d;
            left_cur_q   <= left_cur_d;
            left_above_q <= left_above_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            win_eol_q    <= win_eol_d;
        end
    end

    assign win_data  = win_q;
    assign win_valid = win_valid_q;
    assign win_eol   = win_eol_q;

endmodule
